// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: funct codes, FSM states, default width.
package mips_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DIV   = 2'd2,
    FIXUP = 2'd3
  } md_state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side bundle of the multiply/divide unit; master drives the operation, slave is the unit.
interface ex_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             in_Ctrl_MulDiv;
  logic [5:0]       in_funct;
  logic [WIDTH-1:0] in_ReadData1;
  logic [WIDTH-1:0] in_ReadData2;
  logic             in_Flush;
  logic             out_Stall;
  logic             out_Busy;
  logic [WIDTH-1:0] out_Result;
  logic [WIDTH-1:0] out_HI;
  logic [WIDTH-1:0] out_LO;

  modport master (
    output in_Ctrl_MulDiv, in_funct, in_ReadData1, in_ReadData2, in_Flush,
    input  out_Stall, out_Busy, out_Result, out_HI, out_LO
  );

  modport slave (
    input  in_Ctrl_MulDiv, in_funct, in_ReadData1, in_ReadData2, in_Flush,
    output out_Stall, out_Busy, out_Result, out_HI, out_LO
  );
endinterface

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: one shift-add (multiply) or restoring (divide) step per cycle.
// After WIDTH steps {acc_hi,acc_lo} holds the product, or remainder/quotient for a divide.
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             load_div,
  input  logic             step,
  input  logic             step_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic             last
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;

  assign last = (cnt == CW'(1));

  // Multiply: conditionally add multiplicand into the upper half, then shift the pair right.
  assign mul_sum  = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd}) : {1'b0, acc_hi};
  // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = {1'b0, div_sh} - {2'b00, opnd};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc_hi <= '0;
      acc_lo <= load_div ? opa : opb;
      opnd   <= load_div ? opb : opa;
      cnt    <= CW'(WIDTH);
    end else if (step) begin
      cnt <= cnt - CW'(1);
      if (step_div) begin
        if (!div_diff[WIDTH+1]) begin
          acc_hi <= div_diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi <= div_sh[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, sequences the iterative core, applies sign fixup,
// serves MFHI/MFLO/MTHI/MTLO and freezes the front end while an operation is in flight.
module ex_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic              clk,
  input logic              reset,
  ex_muldiv_unit_if.slave  bus
);
  md_state_t        state;
  logic             busy;
  logic             op_div;
  logic             neg_lo;
  logic             neg_hi;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic             idle_req;
  logic             is_mul;
  logic             is_div;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             core_load;
  logic             core_step;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  logic             core_last;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign idle_req  = (state == IDLE) && bus.in_Ctrl_MulDiv && !bus.in_Flush;
  assign is_mul    = (bus.in_funct == FUNCT_MULT) || (bus.in_funct == FUNCT_MULTU);
  assign is_div    = (bus.in_funct == FUNCT_DIV)  || (bus.in_funct == FUNCT_DIVU);
  assign is_signed = (bus.in_funct == FUNCT_MULT) || (bus.in_funct == FUNCT_DIV);
  assign a_neg     = is_signed && bus.in_ReadData1[WIDTH-1];
  assign b_neg     = is_signed && bus.in_ReadData2[WIDTH-1];
  assign a_mag     = a_neg ? (~bus.in_ReadData1 + WIDTH'(1)) : bus.in_ReadData1;
  assign b_mag     = b_neg ? (~bus.in_ReadData2 + WIDTH'(1)) : bus.in_ReadData2;

  assign core_load = idle_req && (is_mul || is_div);
  assign core_step = !bus.in_Flush && ((state == MUL) || (state == DIV));

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .load_div (is_div),
    .step     (core_step),
    .step_div (state == DIV),
    .opa      (a_mag),
    .opb      (b_mag),
    .acc_hi   (core_hi),
    .acc_lo   (core_lo),
    .last     (core_last)
  );

  assign prod_fix = neg_lo ? (~{core_hi, core_lo} + (2*WIDTH)'(1)) : {core_hi, core_lo};
  assign quot_fix = neg_lo ? (~core_lo + WIDTH'(1)) : core_lo;
  assign rem_fix  = neg_hi ? (~core_hi + WIDTH'(1)) : core_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      op_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (bus.in_Flush) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_Ctrl_MulDiv) begin
            if (is_mul || is_div) begin
              state  <= is_div ? DIV : MUL;
              busy   <= 1'b1;
              op_div <= is_div;
              // A zero divisor keeps the all-ones quotient regardless of operand signs.
              neg_lo <= (a_neg ^ b_neg) && !(is_div && (bus.in_ReadData2 == '0));
              neg_hi <= is_div && a_neg;
            end else if (bus.in_funct == FUNCT_MTHI) begin
              hi <= bus.in_ReadData1;
            end else if (bus.in_funct == FUNCT_MTLO) begin
              lo <= bus.in_ReadData1;
            end
          end
        end
        MUL, DIV: begin
          if (core_last) state <= FIXUP;
        end
        FIXUP: begin
          if (op_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.out_Result = '0;
    if ((state == IDLE) && bus.in_Ctrl_MulDiv) begin
      if (bus.in_funct == FUNCT_MFHI)      bus.out_Result = hi;
      else if (bus.in_funct == FUNCT_MFLO) bus.out_Result = lo;
    end
  end

  assign bus.out_Stall = bus.in_Ctrl_MulDiv && (state != IDLE);
  assign bus.out_Busy  = busy;
  assign bus.out_HI    = hi;
  assign bus.out_LO    = lo;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: arithmetic reference model checked every cycle plus literal pins.
module tb_ex_muldiv_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  ex_muldiv_unit_if #(.WIDTH(32)) bus ();

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {HI,LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      FUNCT_MULT:  return 64'(sa * sb);
      FUNCT_MULTU: return ua * ub;
      FUNCT_DIV: begin
        if (b == 32'b0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'b0) return {a, 32'hFFFFFFFF};
        q = longint'(ua / ub);
        r = longint'(ua % ub);
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_rem;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= '0;
      m_rem  <= 0;
    end else if (bus.in_Flush) begin
      m_rem <= 0;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (bus.in_Ctrl_MulDiv) begin
      case (bus.in_funct)
        FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
          m_pend <= ref_op(bus.in_funct, bus.in_ReadData1, bus.in_ReadData2);
          m_rem  <= 33;
        end
        FUNCT_MTHI: m_hi <= bus.in_ReadData1;
        FUNCT_MTLO: m_lo <= bus.in_ReadData1;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      logic        e_busy;
      logic [31:0] e_res;
      e_busy = (m_rem != 0);
      e_res  = 32'b0;
      if (!e_busy && bus.in_Ctrl_MulDiv) begin
        if (bus.in_funct == FUNCT_MFHI)      e_res = m_hi;
        else if (bus.in_funct == FUNCT_MFLO) e_res = m_lo;
      end
      chk("model_hi",     bus.out_HI, m_hi);
      chk("model_lo",     bus.out_LO, m_lo);
      chk("model_busy",   32'(bus.out_Busy), 32'(e_busy));
      chk("model_stall",  32'(bus.out_Stall), 32'(bus.in_Ctrl_MulDiv && e_busy));
      chk("model_result", bus.out_Result, e_res);
    end
  end

  task automatic drive(input logic ctrl, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.in_Ctrl_MulDiv = ctrl;
    bus.in_funct       = f;
    bus.in_ReadData1   = a;
    bus.in_ReadData2   = b;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, f, a, b);
    @(posedge clk);
    #1;
    drive(1'b0, FUNCT_MFHI, 32'h0, 32'h0);
  endtask

  // Counts busy cycles after a start; ends on the first sampled non-busy cycle.
  task automatic wait_idle(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!bus.out_Busy) break;
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(f, a, b);
    wait_idle(n);
    chk({name, "_busy_cycles"}, 32'(n), 32'd33);
    chk({name, "_hi"}, bus.out_HI, exp_hi);
    chk({name, "_lo"}, bus.out_LO, exp_lo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bus.in_Flush = 1'b0;
    drive(1'b0, FUNCT_MFHI, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("reset_hi",     bus.out_HI, 32'h0);
    chk("reset_lo",     bus.out_LO, 32'h0);
    chk("reset_busy",   32'(bus.out_Busy), 32'h0);
    chk("reset_stall",  32'(bus.out_Stall), 32'h0);
    chk("reset_result", bus.out_Result, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("mult_neg",   FUNCT_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max",  FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_neg",    FUNCT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_zero",  FUNCT_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
    run_op("div_ovf",    FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_zero_s", FUNCT_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("divu_big",   FUNCT_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC);

    // MFLO presented the cycle after MULT must stall until the product lands.
    issue(FUNCT_MULT, 32'd6, 32'd7);
    drive(1'b1, FUNCT_MFLO, 32'h0, 32'h0);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!bus.out_Stall) break;
      n++;
    end
    chk("mflo_stall_cycles", 32'(n), 32'd33);
    chk("mflo_result", bus.out_Result, 32'd42);
    @(posedge clk);
    #1 drive(1'b0, FUNCT_MFHI, 32'h0, 32'h0);

    // Flush at iteration 10 of a divide leaves HI/LO untouched.
    issue(FUNCT_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 bus.in_Flush = 1'b1;
    @(posedge clk);
    #1 bus.in_Flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(bus.out_Busy), 32'h0);
    chk("flush_hi",   bus.out_HI, 32'h0);
    chk("flush_lo",   bus.out_LO, 32'd42);

    // Flush on the same cycle as a start drops the start.
    @(posedge clk);
    #1 bus.in_Flush = 1'b1;
    issue(FUNCT_MULT, 32'd3, 32'd3);
    bus.in_Flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", 32'(bus.out_Busy), 32'h0);

    // Undefined funct is ignored.
    issue(6'h3F, 32'hDEAD, 32'hBEEF);
    @(negedge clk);
    chk("undef_busy", 32'(bus.out_Busy), 32'h0);
    chk("undef_hi",   bus.out_HI, 32'h0);

    // MTHI then MFHI back-to-back.
    @(posedge clk);
    #1 issue(FUNCT_MTHI, 32'h1234, 32'h0);
    drive(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    chk("mfhi_result", bus.out_Result, 32'h1234);
    chk("mfhi_stall",  32'(bus.out_Stall), 32'h0);
    @(posedge clk);
    #1 drive(1'b0, FUNCT_MFHI, 32'h0, 32'h0);
    issue(FUNCT_MTLO, 32'h5678, 32'h0);
    @(negedge clk);
    chk("mtlo_lo", bus.out_LO, 32'h5678);

    // Reset pulse in the middle of a multiply.
    issue(FUNCT_MULT, 32'd5, 32'd5);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midreset_hi",   bus.out_HI, 32'h0);
    chk("midreset_lo",   bus.out_LO, 32'h0);
    chk("midreset_busy", 32'(bus.out_Busy), 32'h0);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_op("post_reset", FUNCT_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
